// File: rtl/wishbone_cmd_master.sv
// wishbone_cmd_master: single-outstanding Wishbone B4 pipelined master driven by a valid/ready command stream.
// Ports:
//   i_clk, i_reset_n                    clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready             command handshake (ready only while idle)
//   i_cmd_we, i_cmd_addr, i_cmd_data    command fields, latched on accept
//   o_rsp_valid, o_rsp_err, o_rsp_data  one-cycle response pulse
//   o_wb_cyc/stb/we/addr/odata          Wishbone request outputs
//   i_wb_ack/stall/err/idata            Wishbone slave returns
// Optional: define WB_CMD_MASTER_TIMEOUT_EN to abort transactions left unanswered
// for TIMEOUT_CYCLES cycles of o_wb_cyc; otherwise the master waits indefinitely.
module wishbone_cmd_master #(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_we,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_data,
    output logic                  o_rsp_valid,
    output logic                  o_rsp_err,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_WIDTH-1:0] o_wb_addr,
    output logic [DATA_WIDTH-1:0] o_wb_odata,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_stall,
    input  logic                  i_wb_err,
    input  logic [DATA_WIDTH-1:0] i_wb_idata
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3;
    logic [1:0]            state_q, state_d;
    logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] odata_q, odata_d, rsp_data_q, rsp_data_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic                  tmo;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // cnt_q counts completed cyc cycles; the edge ending cycle TIMEOUT_CYCLES aborts.
    assign tmo   = cnt_q == TLAST;
    assign cnt_d = (state_q == IDLE) ? '0 : cyc_q ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
`else
    assign tmo = 1'b0;
`endif
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        odata_d     = odata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: if (i_cmd_valid) begin
                state_d = REQ;
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                we_d    = i_cmd_we;
                addr_d  = i_cmd_addr;
                odata_d = i_cmd_data;
            end
            REQ, WAIT: if (i_wb_ack || i_wb_err || tmo) begin
                state_d     = RESP;
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b1;
                // err beats ack; a timeout is an error unless ack lands on the same edge
                rsp_err_d   = i_wb_err || !i_wb_ack;
                rsp_data_d  = rsp_err_d ? '0 : we_q ? rsp_data_q : i_wb_idata;
            end else if (state_q == REQ && !i_wb_stall) begin
                state_d = WAIT;
                stb_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_reset_n)
        if (!i_reset_n) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            odata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            odata_q     <= odata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    assign o_cmd_ready = state_q == IDLE;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_wb_we     = we_q;
    assign o_wb_addr   = addr_q;
    assign o_wb_odata  = odata_q;
endmodule

// File: tb/tb_wishbone_cmd_master.sv
// tb_wishbone_cmd_master: directed and randomized checks of wishbone_cmd_master against a transaction-level model.
module tb_wishbone_cmd_master;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [1:0]  cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic        wb_cyc, wb_stb, wb_we;
    logic [1:0]  wb_addr;
    logic [31:0] wb_odata;
    logic        ack = 1'b0, stall = 1'b0, err = 1'b0;
    logic [31:0] idata = '0;
    int          errors = 0, checks = 0;
    logic [31:0] last_data = '0;

    wishbone_cmd_master dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_we(cmd_we),
        .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
        .o_rsp_valid(rsp_valid), .o_rsp_err(rsp_err), .o_rsp_data(rsp_data),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_addr(wb_addr), .o_wb_odata(wb_odata),
        .i_wb_ack(ack), .i_wb_stall(stall), .i_wb_err(err), .i_wb_idata(idata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one command at a negedge; returns at the negedge after the accept edge.
    task automatic start_cmd(input logic we, input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_data = data;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = ~we; cmd_addr = ~addr; cmd_data = $urandom;
    endtask

    // Slave stalls s cycles, then accepts; responds d cycles after the accept edge.
    task automatic do_txn(input logic we, input logic [1:0] addr, input logic [31:0] data,
                          input int s, input int d, input logic a, input logic e, input logic [31:0] rdata);
        int stb_n = 0, cyc_n = 0, rsp_n = 0, rsp_at = -1, rdy_bad = 0, hold_bad = 0;
        logic [31:0] got_d = '0, exp_d;
        logic got_e = 1'b0, exp_e;
        exp_e = e;
        exp_d = e ? 32'h0 : (we ? last_data : rdata);
        start_cmd(we, addr, data);
        for (int c = 0; c <= s + d + 2; c++) begin
            stb_n += int'(wb_stb);
            cyc_n += int'(wb_cyc);
            if (rsp_valid) begin rsp_n++; rsp_at = c; got_d = rsp_data; got_e = rsp_err; end
            if (cmd_ready !== (c == s + d + 2)) rdy_bad++;
            if (wb_cyc && (wb_addr !== addr || wb_we !== we || wb_odata !== data)) hold_bad++;
            stall = c < s;
            ack   = (c == s + d) && a;
            err   = (c == s + d) && e;
            idata = (c == s + d) ? rdata : $urandom;
            if (c < s + d + 2) @(negedge clk);
        end
        ack = 1'b0; err = 1'b0; stall = 1'b0;
        chk("stb_cycles", stb_n, s + 1);
        chk("cyc_cycles", cyc_n, s + d + 1);
        chk("rsp_count", rsp_n, 1);
        chk("rsp_timing", rsp_at, s + d + 1);
        chk("ready_pattern", rdy_bad, 0);
        chk("req_hold", hold_bad, 0);
        chk("rsp_err", got_e, exp_e);
        chk("rsp_data", got_d, exp_d);
        last_data = exp_d;
    endtask

    initial begin
        int cyc_n, rsp_n;
        logic [31:0] got_d;
        logic got_e;
        #12;
        chk("rst_cyc", wb_cyc, 0);
        chk("rst_stb", wb_stb, 0);
        chk("rst_we", wb_we, 0);
        chk("rst_addr", wb_addr, 0);
        chk("rst_odata", wb_odata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        do_txn(1'b1, 2'd1, 32'h1, 0, 1, 1'b1, 1'b0, 32'h0);
        do_txn(1'b0, 2'd2, 32'h0, 0, 0, 1'b1, 1'b0, 32'hDEADBEEF);
        do_txn(1'b1, 2'd3, 32'hCAFE0001, 3, 2, 1'b1, 1'b0, 32'h12345678);
        do_txn(1'b0, 2'd1, 32'h0, 1, 1, 1'b1, 1'b1, 32'hA5A5A5A5);
        do_txn(1'b1, 2'd0, 32'h55, 0, 2, 1'b0, 1'b1, 32'h0);

        // Stray ack/err while idle must be ignored
        @(negedge clk);
        ack = 1'b1; err = 1'b1;
        @(negedge clk);
        chk("stray_no_rsp", rsp_valid, 0);
        chk("stray_no_cyc", wb_cyc, 0);
        chk("stray_ready", cmd_ready, 1);
        ack = 1'b0; err = 1'b0;

        for (int i = 0; i < 24; i++)
            do_txn(1'($urandom), 2'($urandom), $urandom, int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 4)), 1'($urandom), 1'b1, $urandom);
        for (int i = 0; i < 16; i++) begin
            logic e = 1'($urandom);
            do_txn(1'($urandom), 2'($urandom), $urandom, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), ~e | 1'($urandom), e, $urandom);
        end

        // Unanswered transaction
        start_cmd(1'b0, 2'd2, 32'h0);
        cyc_n = 0; rsp_n = 0; got_d = '1; got_e = 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        for (int c = 0; c < 40; c++) begin
            cyc_n += int'(wb_cyc);
            if (rsp_valid) begin rsp_n++; got_d = rsp_data; got_e = rsp_err; end
            @(negedge clk);
        end
        chk("tmo_cyc_cycles", cyc_n, 15);
        chk("tmo_rsp_count", rsp_n, 1);
        chk("tmo_rsp_err", got_e, 1);
        chk("tmo_rsp_data", got_d, 0);
        last_data = '0;
`else
        for (int c = 0; c < 100; c++) begin
            cyc_n += int'(wb_cyc);
            rsp_n += int'(rsp_valid);
            @(negedge clk);
        end
        chk("notmo_cyc_cycles", cyc_n, 100);
        chk("notmo_cyc_high", wb_cyc, 1);
        chk("notmo_rsp_count", rsp_n, 0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_data = '0;
`endif

        // Reset while waiting for the slave
        start_cmd(1'b0, 2'd3, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("wait_cyc", wb_cyc, 1);
        chk("wait_stb", wb_stb, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc", wb_cyc, 0);
        chk("arst_stb", wb_stb, 0);
        chk("arst_ready", cmd_ready, 1);
        rsp_n = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rsp_n += int'(rsp_valid);
        end
        chk("arst_no_rsp", rsp_n, 0);
        rst_n = 1'b1;
        last_data = '0;
        @(negedge clk);
        chk("arst_ready_after", cmd_ready, 1);
        do_txn(1'b0, 2'd1, 32'h0, 1, 1, 1'b1, 1'b0, 32'h0BADF00D);
        do_txn(1'b1, 2'd2, 32'h77, 0, 0, 1'b1, 1'b0, 32'hFFFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
